unsigned_mul_approx_pipe: RTL and testbench

UNSIGNED_MUL_APPROX_PIPE -- requirements
Module: unsigned_mul_approx_pipe

---
 rtl/unsigned_mul_approx_pipe.sv | 117 +++++++++++
 tb/tb_unsigned_mul_approx_pipe.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unsigned_mul_approx_pipe.sv
// Pipelined unsigned W x W multiplier with per-transaction column truncation.
// Columns below lvl are dropped; stage 1 reduces to two rows, the last stage adds them.
module unsigned_mul_approx_pipe #(
  parameter int unsigned W      = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned LW     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    x,
  input  logic [W-1:0]    y,
  input  logic [LW-1:0]   lvl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  z,
  output logic            busy
);

  localparam int unsigned P = 2 * W;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] up_v;
  logic [P-1:0]      mask;
  logic [P-1:0]      row;
  logic [P-1:0]      carry;
  logic [P-1:0]      red_s;
  logic [P-1:0]      red_c;
  logic              r;

  // Masked partial products folded into a sum/carry pair by a chain of 3:2 compressors
  always_comb begin
    mask  = '0;
    row   = '0;
    carry = '0;
    red_s = '0;
    red_c = '0;
    for (int unsigned c = 0; c < P; c++) begin
      mask[c] = (32'(lvl) <= c);
    end
    for (int unsigned j = 0; j < W; j++) begin
      row   = (P'(x) << j) & mask & {P{y[j]}};
      carry = (red_s & red_c) | (red_s & row) | (red_c & row);
      red_s = red_s ^ red_c ^ row;
      red_c = carry << 1;
    end
  end

  // Stall chain: a stage is ready when empty or when its successor is ready
  always_comb begin
    rdy  = '0;
    up_v = '0;
    r    = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      r      = ~v[k] | r;
      rdy[k] = r;
    end
    up_v[0] = in_valid;
    for (int k = 1; k < int'(STAGES); k++) begin
      up_v[k] = v[k-1];
    end
  end

  assign in_ready  = rdy[0] & ~rst;
  assign out_valid = v[STAGES-1];
  assign busy      = |v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (rdy[k]) v[k] <= up_v[k];
      end
    end
  end

  generate
    if (STAGES == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          z <= '0;
        end else if (rdy[0] && in_valid) begin
          z <= red_s + red_c;
        end
      end
    end else begin : g_multi
      logic [P-1:0] ps [STAGES-1];
      logic [P-1:0] pc [STAGES-1];

      // Carry-save pair travels through the middle stages unchanged
      always_ff @(posedge clk) begin
        if (rdy[0] && in_valid) begin
          ps[0] <= red_s;
          pc[0] <= red_c;
        end
        for (int k = 1; k < int'(STAGES) - 1; k++) begin
          if (rdy[k] && v[k-1]) begin
            ps[k] <= ps[k-1];
            pc[k] <= pc[k-1];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          z <= '0;
        end else if (rdy[STAGES-1] && v[STAGES-2]) begin
          z <= ps[STAGES-2] + pc[STAGES-2];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_unsigned_mul_approx_pipe.sv
// Randomized self-checking bench for unsigned_mul_approx_pipe against a
// column-truncated product model, covering latency, streaming, stalls and reset.
module tb_unsigned_mul_approx_pipe;

  localparam int unsigned W      = 8;
  localparam int unsigned STAGES = 2;
  localparam int unsigned LW     = 5;
  localparam int unsigned P      = 2 * W;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [LW-1:0] lvl;
  logic          out_valid;
  logic          out_ready;
  logic [P-1:0]  z;
  logic          busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [P-1:0] exp_q [$];
  logic [P-1:0] got_q [$];
  int           got_t [$];

  unsigned_mul_approx_pipe #(.W(W), .STAGES(STAGES), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .lvl       (lvl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Sum of every partial-product bit whose column weight is at least l
  function automatic logic [P-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [LW-1:0] l);
    longint unsigned acc = 0;
    for (int i = 0; i < int'(W); i++)
      for (int j = 0; j < int'(W); j++)
        if ((i + j) >= int'(l) && a[i] && b[j]) acc += 64'(1) << (i + j);
    return P'(acc);
  endfunction

  // Record transfers half a cycle before the edge that performs them
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) exp_q.push_back(model(x, y, lvl));
    if (!rst && out_valid && out_ready) begin
      got_q.push_back(z);
      got_t.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    exp_q.delete();
    got_q.delete();
    got_t.delete();
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [LW-1:0] l, output bit ok);
    in_valid = 1'b1;
    x = a;
    y = b;
    lvl = l;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand(output bit ok);
    send(W'($urandom), W'($urandom), LW'($urandom_range(0, (1 << LW) - 1)), ok);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && busy; t++) tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_timeout: busy=%b required 0", busy);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    lvl = '0;
    repeat (3) tick();
    tests_run += 4;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (z !== '0) begin tests_failed++; $display("FAIL rst_z: got %0d required 0", z); end
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    rst = 1'b0;
    tick();
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_rst_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_directed();
    int xs [4] = '{255, 255, 3, 200};
    int ys [4] = '{255, 255, 3, 77};
    int ls [4] = '{0, 8, 1, 15};
    int ez [4] = '{65025, 63232, 8, 0};
    flush();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = W'(xs[i]);
      y = W'(ys[i]);
      lvl = LW'(ls[i]);
      in_valid = 1'b1;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL dir%0d_in_ready: got %b required 1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < int'(STAGES) - 1; k++) begin
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL dir%0d_early_valid: got %b required 0", i, out_valid); end
        tick();
      end
      tests_run += 2;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL dir%0d_latency: out_valid=%b required 1", i, out_valid); end
      if (z !== P'(ez[i])) begin tests_failed++; $display("FAIL dir%0d_z: got %0d required %0d", i, z, ez[i]); end
      tick();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t0;
    int gaps = 0;
    flush();
    out_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      send_rand(ok);
      if (!ok) begin tests_run++; tests_failed++; $display("FAIL b2b_accept%0d: timed out", i); end
    end
    tests_run++;
    if ((cyc - t0) !== 100) begin tests_failed++; $display("FAIL b2b_input_cycles: got %0d required 100", cyc - t0); end
    drain();
    tests_run++;
    if (got_q.size() !== 100) begin tests_failed++; $display("FAIL b2b_count: got %0d required 100", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL b2b_z%0d: got %0d required %0d", i, got_q[i], exp_q[i]); end
    end
    for (int i = 1; i < got_t.size(); i++) if (got_t[i] - got_t[i-1] != 1) gaps++;
    tests_run++;
    if (gaps !== 0) begin tests_failed++; $display("FAIL b2b_bubbles: got %0d required 0", gaps); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [P-1:0] hold;
    flush();
    out_ready = 1'b0;
    for (int i = 0; i < int'(STAGES); i++) begin
      send_rand(ok);
      if (!ok) begin tests_run++; tests_failed++; $display("FAIL stall_fill%0d: timed out", i); end
    end
    hold = z;
    x = W'($urandom);
    y = W'($urandom);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run += 3;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_in_ready%0d: got %b required 0", c, in_ready); end
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_out_valid%0d: got %b required 1", c, out_valid); end
      if (z !== hold) begin tests_failed++; $display("FAIL stall_z_stable%0d: got %0d required %0d", c, z, hold); end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    tests_run++;
    if (got_q.size() !== int'(STAGES)) begin tests_failed++; $display("FAIL stall_count: got %0d required %0d", got_q.size(), STAGES); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL stall_z%0d: got %0d required %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_full_swap();
    bit ok;
    flush();
    out_ready = 1'b0;
    for (int i = 0; i < int'(STAGES); i++) begin
      send_rand(ok);
      if (!ok) begin tests_run++; tests_failed++; $display("FAIL swap_fill%0d: timed out", i); end
    end
    x = W'($urandom);
    y = W'($urandom);
    lvl = LW'($urandom_range(0, 2 * W));
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    tests_run += 2;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL swap_in_ready: got %b required 1", in_ready); end
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL swap_out_valid: got %b required 1", out_valid); end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    tests_run += 2;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL swap_busy: got %b required 1", busy); end
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL swap_still_full: got %b required 1", out_valid); end
    out_ready = 1'b1;
    drain();
    tests_run++;
    if (got_q.size() !== int'(STAGES) + 1) begin tests_failed++; $display("FAIL swap_count: got %0d required %0d", got_q.size(), STAGES + 1); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL swap_z%0d: got %0d required %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    flush();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send_rand(ok);
      if (!ok) begin tests_run++; tests_failed++; $display("FAIL rmid_fill%0d: timed out", i); end
    end
    rst = 1'b1;
    #1;
    tests_run += 4;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_out_valid: got %b required 0", out_valid); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy: got %b required 0", busy); end
    if (z !== '0) begin tests_failed++; $display("FAIL rmid_z: got %0d required 0", z); end
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rmid_in_ready: got %b required 0", in_ready); end
    flush();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    tests_run++;
    if (got_q.size() !== 0) begin tests_failed++; $display("FAIL rmid_stale: got %0d results required 0", got_q.size()); end
    send_rand(ok);
    if (!ok) begin tests_run++; tests_failed++; $display("FAIL rmid_new_accept: timed out"); end
    drain();
    tests_run++;
    if (got_q.size() !== 1) begin tests_failed++; $display("FAIL rmid_new_count: got %0d required 1", got_q.size()); end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      tests_run++;
      if (got_q[0] !== exp_q[0]) begin tests_failed++; $display("FAIL rmid_new_z: got %0d required %0d", got_q[0], exp_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_full_swap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
